bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the vending machine display path.
//   Takes a binary amount (credit, price or change) and produces four registered BCD digits.
//   Sits directly upstream of the 4-digit seven-segment driver: dig3..dig0 feed in1..in4 (in1 = leftmost).
//   Holds its outputs stable between conversions; adds leading-zero blanking and overflow indication.
// PARAMETERS
//   BIN_W       14     width of bin_in; legal range 4..16
//   BLANK_CODE  4'hF   nibble driven on a blanked digit (decoder renders it dark)
//   OVF_CODE    4'hE   nibble driven on every digit when the value exceeds 9999
// PORTS
//   clk       in   1      system clock, rising edge
//   clr       in   1      reset, asynchronous, active-high
//   bin_in    in   BIN_W  unsigned binary value, sampled only on an accepted start
//   start     in   1      request conversion; accepted when busy=0
//   blank_lz  in   1      leading-zero blanking enable, sampled with bin_in
//   busy      out  1      conversion in progress
//   done      out  1      one-cycle pulse: new digits are valid on this cycle
//   ovf       out  1      registered; 1 = last converted value > 9999
//   dig3      out  4      thousands digit (leftmost)
//   dig2      out  4      hundreds digit
//   dig1      out  4      tens digit
//   dig0      out  4      units digit (rightmost)
// BEHAVIOUR
//   Reset (clr=1, async): state=IDLE; busy=0, done=0, ovf=0, dig3..dig0=4'h0; the working registers are cleared.
//   FSM states: IDLE -> SHIFT -> FORMAT -> IDLE.
//   IDLE: on a clk edge with start=1, latch bin_in into shift_reg, latch blank_lz, and clear the 16-bit BCD accumulator.
//     Set bit_cnt=BIN_W and go to SHIFT. busy=1 from that edge.
//   SHIFT: on each edge, add 3 to every accumulator nibble that is >=5, then shift {bcd,shift_reg} left by 1.
//     Decrement bit_cnt. After exactly BIN_W edges in SHIFT, go to FORMAT.
//   FORMAT (one edge): write dig3..dig0 and ovf, pulse done=1 for exactly one cycle, set busy=0, return to IDLE.
//   Latency: start accepted on edge E0; digits update and done=1 right after edge E0+BIN_W+1.
//     busy is high for BIN_W+1 cycles.
//   Overflow: the zero-extended latched value is compared against 9999 at capture. If it is greater:
//     in FORMAT, all digits = OVF_CODE and ovf=1. Latency is unchanged. Impossible when BIN_W<14.
//   Blanking (blank_lz latched =1, no overflow): dig3, dig2 and dig1 each become BLANK_CODE when
//     that digit and every digit to its left is 0. dig0 is never blanked. Example: 0 -> F,F,F,0.
//   Outputs dig*/ovf change only in FORMAT or on reset. There is no glitching during SHIFT, so the display shows the previous value.
//   start while busy=1: ignored, not queued. start on the same cycle as done: accepted, because the FSM is already in IDLE.
//   start held high: back-to-back conversions, one every BIN_W+2 cycles.
//   clr mid-conversion: abort immediately to the reset values; no done pulse.
//   bin_in and blank_lz may change freely after the start edge.
// STRUCTURE
//   Shared package vm_display_pkg holds:
//     localparam BCD_MAX=9999; the BLANK/OVF code defaults; the FSM state typedef/encoding (IDLE/SHIFT/FORMAT).
//   Sub-module bcd_add3 (combinational, 4b in -> 4b out, +3 if >=5) is instantiated 4x on the accumulator nibbles.
//   bit_cnt width = $clog2(BIN_W+1).
// TESTING
//   T1: reset, then bin_in=1234, blank_lz=0, start pulse -> done exactly BIN_W+1 cycles later; digs=1,2,3,4; ovf=0.
//   T2: bin_in=0, blank_lz=1 -> digs=F,F,F,0. Then bin_in=305, blank_lz=1 -> digs=F,3,0,5 (inner zero kept).
//   T3: bin_in=9999 -> digs=9,9,9,9, ovf=0. Then bin_in=10000 -> digs=E,E,E,E, ovf=1, same latency.
//   T4: second start issued at 5 cycles into a conversion of 42 -> ignored; only one done; digs=0,0,4,2.
//     Then start held high -> done every BIN_W+2 cycles.
//   T5: clr asserted mid-SHIFT during conversion of 777 -> asynchronously busy=0, digs=0,0,0,0, no done.
//     Next start of 777 -> 0,7,7,7.
//   T6: exhaustive 0..9999 with blank_lz=0, checked against a reference model; also verify digs are stable while busy=1.

Source files
------------

// File: rtl/vm_display_pkg.sv
// Shared definitions for the vending machine display path.
//   BCD_MAX         largest value representable on the 4-digit display
//   BLANK_CODE_DEF  default nibble for a blanked (dark) digit
//   OVF_CODE_DEF    default nibble shown on every digit on overflow
//   state_t         converter FSM encoding (IDLE -> SHIFT -> FORMAT)
package vm_display_pkg;

    localparam int         BCD_MAX        = 9999;
    localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
    localparam logic [3:0] OVF_CODE_DEF   = 4'hE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decade.
//   d  in   4   accumulator nibble
//   q  out  4   corrected nibble
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= 4'd5) q = d + 4'd3;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) for the display path.
// Converts a binary amount into four registered BCD digits with optional
// leading-zero blanking and overflow indication; outputs hold between conversions.
//   clk       in   1      system clock, rising edge
//   clr       in   1      asynchronous active-high reset
//   bin_in    in   BIN_W  unsigned value, sampled on an accepted start
//   start     in   1      conversion request, accepted when busy=0
//   blank_lz  in   1      leading-zero blanking enable, sampled with bin_in
//   busy      out  1      conversion in progress
//   done      out  1      one-cycle pulse when new digits are presented
//   ovf       out  1      last converted value exceeded 9999
//   dig3..0   out  4      thousands..units digit (dig3 leftmost)
module bin_to_bcd_seq
    import vm_display_pkg::*;
#(
    parameter int         BIN_W      = 14,
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF,
    parameter logic [3:0] OVF_CODE   = OVF_CODE_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       dig3,
    output logic [3:0]       dig2,
    output logic [3:0]       dig1,
    output logic [3:0]       dig0
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BIN_W-1:0]   shift_reg;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic               blank_q;
    logic               ovf_q;

    for (genvar g = 0; g < 4; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (bcd[4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    // Final display formatting: overflow replaces every digit; otherwise a
    // digit is blanked only if it and all digits to its left are zero.
    function automatic logic [15:0] format_digits(input logic [15:0] b,
                                                  input logic        blank,
                                                  input logic        over);
        logic z3, z2, z1;
        if (over) return {4{OVF_CODE}};
        z3 = blank && (b[15:12] == 4'd0);
        z2 = z3 && (b[11:8] == 4'd0);
        z1 = z2 && (b[7:4] == 4'd0);
        return {z3 ? BLANK_CODE : b[15:12],
                z2 ? BLANK_CODE : b[11:8],
                z1 ? BLANK_CODE : b[7:4],
                b[3:0]};
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            bcd       <= '0;
            blank_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            dig3      <= 4'h0;
            dig2      <= 4'h0;
            dig1      <= 4'h0;
            dig0      <= 4'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        blank_q   <= blank_lz;
                        // zero-extend so the compare is safe for any BIN_W up to 16
                        ovf_q     <= (17'(bin_in) > 17'(BCD_MAX));
                        bcd       <= '0;
                        bit_cnt   <= CNT_W'(BIN_W);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // correct each nibble, then shift {bcd, shift_reg} left by one
                    bcd       <= {bcd_adj[14:0], shift_reg[BIN_W-1]};
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) state <= FORMAT;
                end
                FORMAT: begin
                    {dig3, dig2, dig1, dig0} <= format_digits(bcd, blank_q, ovf_q);
                    ovf   <= ovf_q;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
